// File: rtl/ex_flag_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_flag_stage
// Description : EX->MEM boundary register sitting directly after the
//               addsub_16bit datapath. Captures the (already saturated)
//               ALU result with its destination info, owns the
//               architectural N/Z/V flag register and counts retired ops.
//               Supports pipeline stall (hold) and flush (bubble).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DST_W        width of the destination register index
//   CNT_W        width of the retired-op counter (wraps modulo 2^CNT_W)
// Ports
//   clk          clock, all state changes on the rising edge
//   rst_n        synchronous active-low reset, clears every register
//   stall        hold all state this edge
//   flush        load a bubble this edge (takes priority over stall)
//   in_valid     EX stage holds a real instruction
//   op           00 ADD, 01 SUB, 10 PADDSB, 11 RED
//   a, b         ALU operands, identical to those driven to addsub_16bit
//   s            saturated addsub_16bit result
//   in_dst       destination register index
//   in_wr_en     instruction writes the register file
//   out_valid    MEM-stage instruction valid
//   out_result   registered s
//   out_dst      registered in_dst
//   out_wr_en    registered in_wr_en & in_valid
//   flag_n/z/v   negative / zero / signed-overflow flags
//   retired_cnt  number of valid ops captured on load edges
// ============================================================================
module ex_flag_stage #(
  parameter int DST_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [1:0]       op,
  input  logic [15:0]      a,
  input  logic [15:0]      b,
  input  logic [15:0]      s,
  input  logic [DST_W-1:0] in_dst,
  input  logic             in_wr_en,
  output logic             out_valid,
  output logic [15:0]      out_result,
  output logic [DST_W-1:0] out_dst,
  output logic             out_wr_en,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_v,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam logic [1:0] c_op_add    = 2'b00;
  localparam logic [1:0] c_op_sub    = 2'b01;
  localparam logic [1:0] c_op_paddsb = 2'b10;
  localparam logic [1:0] c_op_red    = 2'b11;

  // --------------------------------------------------------------------------
  // Pipeline registers
  // --------------------------------------------------------------------------
  logic             r_valid;
  logic [15:0]      r_result;
  logic [DST_W-1:0] r_dst;
  logic             r_wr_en;
  logic             r_flag_n;
  logic             r_flag_z;
  logic             r_flag_v;
  logic [CNT_W-1:0] r_cnt;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic             w_load;
  logic             w_is_arith;
  logic             w_flag_upd;
  logic [15:0]      w_raw_add;
  logic [15:0]      w_raw_sub;
  logic             w_ovf_add;
  logic             w_ovf_sub;
  logic             w_ovf;

  // A load edge is any edge not overridden by flush or stall; reset is
  // handled separately with the highest priority.
  assign w_load     = !flush && !stall;

  // Only the plain ADD/SUB operations are allowed to touch the flags;
  // the packed (PADDSB) and reduction (RED) modes leave them alone.
  assign w_is_arith = (op == c_op_add) || (op == c_op_sub);
  assign w_flag_upd = in_valid && w_is_arith;

  // Overflow is recomputed from the raw operands because s is saturated:
  // a clamped 0x7FFF/0x8000 no longer carries the overflow information.
  // Only bit 15 of the unsaturated sum/difference is needed.
  assign w_raw_add  = a + b;
  assign w_raw_sub  = a - b;
  assign w_ovf_add  = (a[15] == b[15]) && (w_raw_add[15] != a[15]);
  assign w_ovf_sub  = (a[15] != b[15]) && (w_raw_sub[15] != a[15]);
  assign w_ovf      = (op == c_op_sub) ? w_ovf_sub : w_ovf_add;

  // --------------------------------------------------------------------------
  // State update: reset > flush > stall > load
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_dst    <= '0;
      r_wr_en  <= 1'b0;
      r_flag_n <= 1'b0;
      r_flag_z <= 1'b0;
      r_flag_v <= 1'b0;
      r_cnt    <= '0;
    end else if (flush) begin
      // Bubble: clear the payload, keep architectural flags and counter.
      r_valid  <= 1'b0;
      r_result <= '0;
      r_dst    <= '0;
      r_wr_en  <= 1'b0;
    end else if (w_load) begin
      r_valid  <= in_valid;
      r_result <= s;
      r_dst    <= in_dst;
      r_wr_en  <= in_wr_en && in_valid;
      if (w_flag_upd) begin
        r_flag_n <= s[15];
        r_flag_z <= (s == 16'h0000);
        r_flag_v <= w_ovf;
      end
      // Free-running wrap, no saturation or sticky overflow.
      if (in_valid) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
    // stall: every register holds its value
  end

  // --------------------------------------------------------------------------
  // Outputs come straight from registers
  // --------------------------------------------------------------------------
  assign out_valid   = r_valid;
  assign out_result  = r_result;
  assign out_dst     = r_dst;
  assign out_wr_en   = r_wr_en;
  assign flag_n      = r_flag_n;
  assign flag_z      = r_flag_z;
  assign flag_v      = r_flag_v;
  assign retired_cnt = r_cnt;

  // The PADDSB/RED encodings are named for readability of the op map only.
  logic w_unused_ops;
  assign w_unused_ops = (op == c_op_paddsb) || (op == c_op_red);

endmodule
`default_nettype wire

// File: tb/tb_ex_flag_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_flag_stage
// Description : Scoreboard bench for ex_flag_stage. A driver issues directed
//               and random stimulus, computes the expected register state
//               from arithmetic rules and queues it; a monitor compares the
//               DUT after every rising edge. A second instance with a 4-bit
//               counter shares the inputs to exercise counter wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_flag_stage;

  localparam int DST_W = 4;

  logic             clk;
  logic             rst_n;
  logic             stall;
  logic             flush;
  logic             in_valid;
  logic [1:0]       op;
  logic [15:0]      a;
  logic [15:0]      b;
  logic [15:0]      s;
  logic [DST_W-1:0] in_dst;
  logic             in_wr_en;

  logic             out_valid;
  logic [15:0]      out_result;
  logic [DST_W-1:0] out_dst;
  logic             out_wr_en;
  logic             flag_n;
  logic             flag_z;
  logic             flag_v;
  logic [15:0]      retired_cnt;

  logic             out_valid4;
  logic [15:0]      out_result4;
  logic [DST_W-1:0] out_dst4;
  logic             out_wr_en4;
  logic             flag_n4;
  logic             flag_z4;
  logic             flag_v4;
  logic [3:0]       retired_cnt4;

  ex_flag_stage #(.DST_W(DST_W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .op(op), .a(a), .b(b), .s(s),
    .in_dst(in_dst), .in_wr_en(in_wr_en),
    .out_valid(out_valid), .out_result(out_result), .out_dst(out_dst),
    .out_wr_en(out_wr_en), .flag_n(flag_n), .flag_z(flag_z),
    .flag_v(flag_v), .retired_cnt(retired_cnt)
  );

  ex_flag_stage #(.DST_W(DST_W), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .op(op), .a(a), .b(b), .s(s),
    .in_dst(in_dst), .in_wr_en(in_wr_en),
    .out_valid(out_valid4), .out_result(out_result4), .out_dst(out_dst4),
    .out_wr_en(out_wr_en4), .flag_n(flag_n4), .flag_z(flag_z4),
    .flag_v(flag_v4), .retired_cnt(retired_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        valid;
    logic [15:0] result;
    logic [3:0]  dst;
    logic        wr;
    logic        n;
    logic        z;
    logic        v;
    int unsigned cnt;
  } exp_t;

  exp_t exp_q[$];
  int   tests;
  int   fails;

  // Reference state (architectural view)
  logic        m_valid;
  logic [15:0] m_result;
  logic [3:0]  m_dst;
  logic        m_wr;
  logic        m_n;
  logic        m_z;
  logic        m_v;
  int unsigned m_cnt;

  // Apply one cycle of inputs, advance the model, queue the expectation.
  task automatic drive(input string tag, input logic rn, input logic fl,
                       input logic st, input logic vl, input logic [1:0] o,
                       input logic [15:0] ia, input logic [15:0] ib,
                       input logic [15:0] is, input logic [3:0] d,
                       input logic w);
    exp_t e;
    int   sum;
    rst_n = rn; flush = fl; stall = st; in_valid = vl; op = o;
    a = ia; b = ib; s = is; in_dst = d; in_wr_en = w;
    if (!rn) begin
      m_valid = 0; m_result = 0; m_dst = 0; m_wr = 0;
      m_n = 0; m_z = 0; m_v = 0; m_cnt = 0;
    end else if (fl) begin
      m_valid = 0; m_result = 0; m_dst = 0; m_wr = 0;
    end else if (!st) begin
      m_valid  = vl;
      m_result = is;
      m_dst    = d;
      m_wr     = w & vl;
      if (vl && (o == 2'b00 || o == 2'b01)) begin
        sum = (o == 2'b00) ? int'($signed(ia)) + int'($signed(ib))
                           : int'($signed(ia)) - int'($signed(ib));
        m_v = (sum > 32767) || (sum < -32768);
        m_n = is[15];
        m_z = (is == 16'h0000);
      end
      if (vl) m_cnt = m_cnt + 1;
    end
    e.tag = tag; e.valid = m_valid; e.result = m_result; e.dst = m_dst;
    e.wr = m_wr; e.n = m_n; e.z = m_z; e.v = m_v; e.cnt = m_cnt;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: one comparison per rising edge that has a queued expectation.
  initial begin
    exp_t e;
    logic ok;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        ok = (out_valid === e.valid) && (out_result === e.result) &&
             (out_dst === e.dst) && (out_wr_en === e.wr) &&
             (flag_n === e.n) && (flag_z === e.z) && (flag_v === e.v) &&
             (retired_cnt === 16'(e.cnt)) && (retired_cnt4 === 4'(e.cnt)) &&
             (out_valid4 === e.valid) && (out_result4 === e.result) &&
             (flag_v4 === e.v);
        if (!ok) begin
          fails++;
          $display("FAIL %s: got v=%b r=%h d=%h w=%b nzv=%b%b%b cnt=%0d cnt4=%0d ; want v=%b r=%h d=%h w=%b nzv=%b%b%b cnt=%0d cnt4=%0d",
                   e.tag, out_valid, out_result, out_dst, out_wr_en,
                   flag_n, flag_z, flag_v, retired_cnt, retired_cnt4,
                   e.valid, e.result, e.dst, e.wr, e.n, e.z, e.v,
                   e.cnt & 32'hFFFF, e.cnt & 32'hF);
        end
      end
    end
  end

  initial begin
    logic        r_rn, r_fl, r_st, r_vl, r_w;
    logic [1:0]  r_op;
    logic [15:0] r_a, r_b, r_s;
    logic [3:0]  r_d;
    tests = 0; fails = 0;
    m_valid = 0; m_result = 0; m_dst = 0; m_wr = 0;
    m_n = 0; m_z = 0; m_v = 0; m_cnt = 0;

    // Reset
    drive("reset0", 0, 0, 0, 0, 2'b00, 16'h0, 16'h0, 16'h0, 4'h0, 0);
    drive("reset1", 0, 0, 0, 1, 2'b00, 16'h1234, 16'h1, 16'h5, 4'h7, 1);

    // Saturated positive add
    drive("add_sat", 1, 0, 0, 1, 2'b00, 16'h7000, 16'h2000, 16'h7FFF, 4'h3, 1);
    // Zero result, then saturated negative subtract
    drive("sub_zero", 1, 0, 0, 1, 2'b01, 16'h0005, 16'h0005, 16'h0000, 4'h4, 1);
    drive("sub_sat", 1, 0, 0, 1, 2'b01, 16'h8000, 16'h0001, 16'h8000, 4'h5, 1);
    // PADDSB / RED leave flags
    drive("sub_zero2", 1, 0, 0, 1, 2'b01, 16'h0005, 16'h0005, 16'h0000, 4'h6, 1);
    drive("paddsb", 1, 0, 0, 1, 2'b10, 16'h7F7F, 16'h0101, 16'h0000, 4'h7, 1);
    drive("red", 1, 0, 0, 1, 2'b11, 16'h8000, 16'h8000, 16'hFFF0, 4'h8, 0);
    // Stall with new ADD inputs
    for (int i = 0; i < 3; i++)
      drive("stall", 1, 0, 1, 1, 2'b00, 16'h7000, 16'h7000, 16'h7FFF, 4'h9, 1);
    // Flush overrides stall
    drive("flush_stall", 1, 0 + 1, 1, 1, 2'b00, 16'h7000, 16'h7000, 16'h7FFF, 4'h9, 1);
    // Get V=1 again then reset mid-stream
    drive("add_ovf", 1, 0, 0, 1, 2'b00, 16'h7000, 16'h7000, 16'h7FFF, 4'hA, 1);
    drive("reset_mid", 0, 0, 0, 1, 2'b00, 16'h1, 16'h1, 16'h2, 4'hB, 1);
    drive("add_after_rst", 1, 0, 0, 1, 2'b00, 16'h0001, 16'h0001, 16'h0002, 4'hC, 1);
    // 16 consecutive valid ops: 4-bit counter wraps
    for (int i = 0; i < 16; i++)
      drive("wrap", 1, 0, 0, 1, 2'(i), 16'(i * 977), 16'(i * 131), 16'(i * 4099), 4'(i), 1);
    // Invalid cycle with wr_en requested
    drive("invalid_wr", 1, 0, 0, 0, 2'b00, 16'h7000, 16'h7000, 16'h7FFF, 4'hD, 1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      r_rn = ($urandom_range(0, 59) != 0);
      r_fl = ($urandom_range(0, 9) == 0);
      r_st = ($urandom_range(0, 7) == 0);
      r_vl = ($urandom_range(0, 3) != 0);
      r_w  = 1'($urandom);
      r_op = 2'($urandom);
      r_a  = 16'($urandom);
      r_b  = 16'($urandom);
      r_s  = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      r_d  = 4'($urandom);
      drive("random", r_rn, r_fl, r_st, r_vl, r_op, r_a, r_b, r_s, r_d, r_w);
    end

    // Drain: every queued expectation must have been consumed
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
